// File: rtl/rf_write_arbiter_if.sv
// Register-file write arbiter bus.
// Groups the three producer handshakes (link, ALU, load), the decode hazard query
// and the registered register-file write port.
//   master : producers / decode / register file side
//   slave  : the arbiter
interface rf_write_arbiter_if #(
  parameter int unsigned REGBITS = 5,
  parameter int unsigned WIDTH   = 32
);
  logic               link_valid;
  logic [WIDTH-1:0]   link_data;
  logic               link_ready;
  logic               alu_valid;
  logic [REGBITS-1:0] alu_rd;
  logic [WIDTH-1:0]   alu_data;
  logic               alu_ready;
  logic               mem_valid;
  logic [REGBITS-1:0] mem_rd;
  logic [WIDTH-1:0]   mem_data;
  logic               mem_ready;
  logic [REGBITS-1:0] rs;
  logic [REGBITS-1:0] rt;
  logic               rs_pending;
  logic               rt_pending;
  logic               wr_en;
  logic [REGBITS-1:0] wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [1:0]         mem_count;

  modport master (
    output link_valid, link_data, alu_valid, alu_rd, alu_data,
           mem_valid, mem_rd, mem_data, rs, rt,
    input  link_ready, alu_ready, mem_ready, rs_pending, rt_pending,
           wr_en, wr_addr, wr_data, mem_count
  );

  modport slave (
    input  link_valid, link_data, alu_valid, alu_rd, alu_data,
           mem_valid, mem_rd, mem_data, rs, rt,
    output link_ready, alu_ready, mem_ready, rs_pending, rt_pending,
           wr_en, wr_addr, wr_data, mem_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Write-port arbiter and load scoreboard for the register file.
// Link, ALU and load writebacks share one write port; one grant per cycle.
// Loads are buffered in a 2-entry FIFO and tracked in a pending scoreboard so
// decode can stall on read-after-write hazards.
// Ports:
//   clk   : system clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : rf_write_arbiter_if slave (requests, readies, hazard query,
//           registered write port wr_en/wr_addr/wr_data, mem_count)
module rf_write_arbiter #(
  parameter int unsigned REGBITS = 5,
  parameter int unsigned WIDTH   = 32
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);
  localparam int unsigned NREGS = 1 << REGBITS;

  // Encoding doubles as the occupancy count driven on mem_count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_e;

  occ_e               occ_q, occ_d;
  logic [REGBITS-1:0] fifo_rd_q   [2];
  logic [WIDTH-1:0]   fifo_data_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [NREGS-1:0]   pending_q, pending_d;
  logic               wr_en_q;
  logic [REGBITS-1:0] wr_addr_q;
  logic [WIDTH-1:0]   wr_data_q;

  logic               link_ready, alu_ready, mem_ready;
  logic               link_xfer, alu_write, push, pop, alu_grant, grant_en;
  logic [REGBITS-1:0] head_rd, grant_addr;
  logic [WIDTH-1:0]   grant_data;

  assign head_rd = fifo_rd_q[rd_ptr_q];

  always_comb begin
    link_ready = !pending_q[NREGS-1];
    mem_ready  = (occ_q != StFull) && !pending_q[bus.mem_rd];
    alu_ready  = !bus.link_valid && !pending_q[bus.alu_rd] && (occ_q != StFull);

    link_xfer  = bus.link_valid && link_ready;
    // Register 0 traffic is accepted but never reaches the write port or FIFO.
    alu_write  = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
    push       = bus.mem_valid && mem_ready && (bus.mem_rd != '0);

    // FIFO head is judged on pre-push occupancy, so a fresh load waits a cycle.
    // FULL beats the ALU; a non-full FIFO only gets the port when the ALU is idle.
    pop        = !link_xfer && ((occ_q == StFull) || ((occ_q == StOne) && !alu_write));
    alu_grant  = !link_xfer && !pop && alu_write;
    grant_en   = link_xfer || pop || alu_grant;

    grant_addr = '0;
    grant_data = '0;
    if (link_xfer) begin
      grant_addr = REGBITS'(NREGS - 1);
      grant_data = bus.link_data;
    end else if (pop) begin
      grant_addr = head_rd;
      grant_data = fifo_data_q[rd_ptr_q];
    end else if (alu_grant) begin
      grant_addr = bus.alu_rd;
      grant_data = bus.alu_data;
    end

    occ_d = occ_q;
    unique case (occ_q)
      StEmpty: if (push) occ_d = StOne;
      StOne: begin
        if (push && !pop)      occ_d = StFull;
        else if (pop && !push) occ_d = StEmpty;
      end
      StFull:  if (pop && !push) occ_d = StOne;
      default: occ_d = StEmpty;
    endcase

    // A load is never accepted for a register already pending, so the clear
    // and set below never target the same bit.
    pending_d = pending_q;
    if (pop)  pending_d[head_rd]    = 1'b0;
    if (push) pending_d[bus.mem_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= StEmpty;
      pending_q   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      occ_q     <= occ_d;
      pending_q <= pending_d;
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= bus.mem_rd;
        fifo_data_q[wr_ptr_q] <= bus.mem_data;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      wr_en_q <= grant_en;
      if (grant_en) begin
        wr_addr_q <= grant_addr;
        wr_data_q <= grant_data;
      end
    end
  end

  assign bus.link_ready = link_ready;
  assign bus.alu_ready  = alu_ready;
  assign bus.mem_ready  = mem_ready;
  assign bus.rs_pending = pending_q[bus.rs];
  assign bus.rt_pending = pending_q[bus.rt];
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.mem_count  = occ_q;
endmodule
